instr_fetch: RTL and testbench

Instruction fetch unit driving the synchronous 8-bit instruction ROM of the 4-bit MIPS-style unicycle core. It owns the program counter, issues `Address` to the ROM, pairs each returned `Instruction` with its PC and a valid flag, and services stall, jump, call/return (via a small return-address stack) and halt. It sits between the instruction ROM and the decode/control logic.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/ret_addr_stack.sv | 41 ++++
 rtl/instr_fetch.sv | 128 ++++++++++++
 tb/tb_instr_fetch.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// Optional perf counters in instr_fetch are enabled by defining INSTR_FETCH_PERF_EN.
package fetch_pkg;
  localparam int              FETCH_ADDR_W       = 8;
  localparam int              FETCH_INSTR_W      = 8;
  localparam int              FETCH_RAS_DEPTH    = 4;
  localparam logic [7:0]      FETCH_RESET_VECTOR = 8'h00;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/ret_addr_stack.sv
// Circular return-address LIFO; a push onto a full stack silently replaces the oldest entry.
module ret_addr_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       Push,
  input  logic                       Pop,
  input  logic [W-1:0]               PushData,
  output logic [W-1:0]               Top,
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       Full,
  output logic                       Empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] top_idx;

  // wr_ptr is the next free slot; when full it also points at the oldest entry.
  assign top_idx = wr_ptr - PTR_W'(1);
  assign Top     = mem[top_idx];
  assign Full    = (Count == ($clog2(DEPTH) + 1)'(DEPTH));
  assign Empty   = (Count == '0);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr <= '0;
      Count  <= '0;
    end else if (Push) begin
      mem[wr_ptr] <= PushData;
      wr_ptr      <= wr_ptr + PTR_W'(1);
      if (!Full) Count <= Count + 1'b1;
    end else if (Pop && !Empty) begin
      wr_ptr <= top_idx;
      Count  <= Count - 1'b1;
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// Fetch unit: owns the PC, drives the 1-cycle ROM, handles stall/jump/call/return/halt.
// Define INSTR_FETCH_PERF_EN to add the FetchCount/StallCount performance counters.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W       = FETCH_ADDR_W,
  parameter int                INSTR_W      = FETCH_INSTR_W,
  parameter int                RAS_DEPTH    = FETCH_RAS_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(FETCH_RESET_VECTOR)
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic [INSTR_W-1:0]          Instruction,
  output logic [ADDR_W-1:0]           Address,
  output logic [INSTR_W-1:0]          InstrOut,
  output logic [ADDR_W-1:0]           PcOut,
  output logic                        Valid,
  input  logic                        Stall,
  input  logic                        Jump,
  input  logic                        Call,
  input  logic                        Return,
  input  logic [ADDR_W-1:0]           Target,
  input  logic                        HaltReq,
  output logic                        Halted,
  output logic                        StackOverflow,
  output logic                        StackUnderflow,
  output fetch_state_e                DebugState,
  output logic [$clog2(RAS_DEPTH):0]  DebugRasCount
`ifdef INSTR_FETCH_PERF_EN
  ,
  output logic [15:0]                 FetchCount,
  output logic [15:0]                 StallCount
`endif
);
  fetch_state_e state, state_next;
  logic [ADDR_W-1:0] ras_top;
  logic ras_push, ras_pop, ras_full, ras_empty;
  logic set_ovf, set_unf;

  // Valid qualifies InstrOut/PcOut every cycle; there is no ready, Stall is the only back-pressure.
  assign InstrOut   = Instruction;
  assign Valid      = (state == ST_RUN);
  assign Halted     = (state == ST_HALT);
  assign DebugState = state;

  ret_addr_stack #(.DEPTH(RAS_DEPTH), .W(ADDR_W)) u_ras (
    .Clock    (Clock),
    .Reset    (Reset),
    .Push     (ras_push),
    .Pop      (ras_pop),
    .PushData (PcOut + ADDR_W'(1)),
    .Top      (ras_top),
    .Count    (DebugRasCount),
    .Full     (ras_full),
    .Empty    (ras_empty)
  );

  // Address is the next PC; holding it at PcOut re-reads the current instruction.
  always_comb begin
    state_next = state;
    Address    = PcOut;
    ras_push   = 1'b0;
    ras_pop    = 1'b0;
    set_ovf    = 1'b0;
    set_unf    = 1'b0;
    unique case (state)
      ST_BOOT: begin
        Address    = RESET_VECTOR;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if (HaltReq) begin
          state_next = ST_HALT;
        end else if (Stall) begin
          Address = PcOut;
        end else if (Return) begin
          if (ras_empty) begin
            set_unf    = 1'b1;
            state_next = ST_HALT;
          end else begin
            Address = ras_top;
            ras_pop = 1'b1;
          end
        end else if (Call) begin
          ras_push = 1'b1;
          set_ovf  = ras_full;
          Address  = Target;
        end else if (Jump) begin
          Address = Target;
        end else begin
          Address = PcOut + ADDR_W'(1);
        end
      end
      default: begin
        state_next = state;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state          <= ST_BOOT;
      PcOut          <= RESET_VECTOR;
      StackOverflow  <= 1'b0;
      StackUnderflow <= 1'b0;
    end else begin
      state          <= state_next;
      PcOut          <= Address;
      StackOverflow  <= StackOverflow | set_ovf;
      StackUnderflow <= StackUnderflow | set_unf;
    end
  end

`ifdef INSTR_FETCH_PERF_EN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      FetchCount <= '0;
      StallCount <= '0;
    end else if (state == ST_RUN) begin
      if (Stall) begin
        if (StallCount != 16'hFFFF) StallCount <= StallCount + 16'd1;
      end else begin
        if (FetchCount != 16'hFFFF) FetchCount <= FetchCount + 16'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch with a queue-based reference model and scoreboard.
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam int W = 24;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  Instruction;
  logic [7:0]  Address, InstrOut, PcOut, Target = 8'h00;
  logic        Valid, Halted, StackOverflow, StackUnderflow;
  logic        Stall = 1'b0, Jump = 1'b0, Call = 1'b0, Return = 1'b0, HaltReq = 1'b0;
  fetch_state_e DebugState;
  logic [2:0]  DebugRasCount;
`ifdef INSTR_FETCH_PERF_EN
  logic [15:0] FetchCount, StallCount;
`endif

  instr_fetch dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .Instruction    (Instruction),
    .Address        (Address),
    .InstrOut       (InstrOut),
    .PcOut          (PcOut),
    .Valid          (Valid),
    .Stall          (Stall),
    .Jump           (Jump),
    .Call           (Call),
    .Return         (Return),
    .Target         (Target),
    .HaltReq        (HaltReq),
    .Halted         (Halted),
    .StackOverflow  (StackOverflow),
    .StackUnderflow (StackUnderflow),
    .DebugState     (DebugState),
    .DebugRasCount  (DebugRasCount)
`ifdef INSTR_FETCH_PERF_EN
    ,
    .FetchCount     (FetchCount),
    .StallCount     (StallCount)
`endif
  );

  // clock / ROM
  always #5 Clock = ~Clock;

  logic [7:0] rom [256];
  always @(posedge Clock) Instruction <= rom[Address];

  // reference model
  bit         m_boot = 1'b1, m_halt = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
  logic [7:0] m_pc = 8'h00;
  logic [7:0] m_stack [$];
  int         m_fetch = 0, m_stall = 0;

  logic [W-1:0] exp_q [$];
  int tests = 0, fails = 0;

  task automatic model_step();
    if (Reset) begin
      m_boot = 1'b1; m_halt = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      m_pc = 8'h00; m_stack.delete(); m_fetch = 0; m_stall = 0;
    end else if (m_boot) begin
      m_boot = 1'b0;
      m_pc   = 8'h00;
    end else if (!m_halt) begin
      if (Stall) m_stall++; else m_fetch++;
      if (HaltReq) m_halt = 1'b1;
      else if (Stall) begin end
      else if (Return) begin
        if (m_stack.size() == 0) begin m_unf = 1'b1; m_halt = 1'b1; end
        else m_pc = m_stack.pop_back();
      end else if (Call) begin
        if (m_stack.size() == 4) begin void'(m_stack.pop_front()); m_ovf = 1'b1; end
        m_stack.push_back(m_pc + 8'd1);
        m_pc = Target;
      end else if (Jump) m_pc = Target;
      else m_pc = m_pc + 8'd1;
    end
  endtask

  function automatic logic [W-1:0] model_out();
    bit v;
    v = !m_boot && !m_halt;
    return {v, v, m_halt, m_ovf, m_unf, 3'(m_stack.size()), m_pc, v ? rom[m_pc] : 8'h00};
  endfunction

  // driver
  task automatic step(input bit rst, hlt, stl, ret, cal, jmp, input logic [7:0] tgt);
    @(negedge Clock);
    Reset = rst; HaltReq = hlt; Stall = stl; Return = ret; Call = cal; Jump = jmp; Target = tgt;
    model_step();
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic goto_pc(input logic [7:0] pc);
    for (int i = 0; i < 300 && (m_pc != pc || m_boot); i++) idle(1);
  endtask

  // scoreboard monitor
  always @(posedge Clock) begin
    #1;
    if (exp_q.size() != 0) begin
      logic [W-1:0] e, a;
      e = exp_q.pop_front();
      a = {e[23], Valid, Halted, StackOverflow, StackUnderflow, DebugRasCount, PcOut,
           e[23] ? InstrOut : 8'h00};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL out @%0t got v=%b h=%b ovf=%b unf=%b ras=%0d pc=%h ins=%h expected v=%b h=%b ovf=%b unf=%b ras=%0d pc=%h ins=%h",
                 $time, a[22], a[21], a[20], a[19], a[18:16], a[15:8], a[7:0],
                 e[22], e[21], e[20], e[19], e[18:16], e[15:8], e[7:0]);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);

    do_reset(); do_reset();
    idle(300);                               // sequential run incl. FF -> 00 wrap

    do_reset(); goto_pc(8'h05);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 1, 8'h77);
    idle(2);

    do_reset(); goto_pc(8'h03);
    step(0, 0, 0, 0, 0, 1, 8'h20); idle(2);

    do_reset(); goto_pc(8'h0A);
    step(0, 0, 0, 0, 1, 0, 8'h40); idle(1);
    step(0, 0, 0, 1, 0, 0, 8'h00); idle(2);

    do_reset(); idle(2);
    for (int i = 1; i <= 5; i++) step(0, 0, 0, 0, 1, 0, 8'(i * 16));
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0, 8'h00);
    step(0, 0, 0, 0, 1, 1, 8'h99); idle(2);   // controls ignored in HALT

    do_reset(); idle(4);
    step(1, 0, 0, 0, 0, 0, 8'h00);          // reset while RUN
    idle(3);
    step(0, 1, 0, 0, 0, 1, 8'hAA); idle(3);
    do_reset(); idle(3);

    for (int i = 0; i < 3000; i++) begin
      bit rst;
      rst = m_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 255) == 0);
      step(rst, $urandom_range(0, 63) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 5) == 0, 8'($urandom));
    end

    @(posedge Clock); #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
`ifdef INSTR_FETCH_PERF_EN
    tests++;
    if (FetchCount !== 16'(m_fetch)) begin
      fails++;
      $display("FAIL fetch_count got %0d expected %0d", FetchCount, m_fetch);
    end
    tests++;
    if (StallCount !== 16'(m_stall)) begin
      fails++;
      $display("FAIL stall_count got %0d expected %0d", StallCount, m_stall);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
